// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass and a per-register
// pending-write scoreboard used by issue logic for RAW detection and back-pressure.
module regfile_mp_sb #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned NR   = 4,
    parameter int unsigned NW   = 3,
    parameter int unsigned NISS = 2,
    parameter int unsigned PW   = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [NR*AW-1:0]  raddr,
    output logic [NR*DW-1:0]  rdata,
    output logic [NR-1:0]     rbusy,
    input  logic [NW-1:0]     we,
    input  logic [NW*AW-1:0]  waddr,
    input  logic [NW*DW-1:0]  wdata,
    input  logic [NW-1:0]     wrel,
    input  logic [NISS-1:0]   iss_valid,
    input  logic [NISS*AW-1:0] iss_addr,
    output logic [NISS-1:0]   iss_ready,
    input  logic              flush,
    output logic              sb_err
);

    // Signed headroom for cnt + issues - releases.
    localparam int unsigned XW = PW + $clog2(NW + NISS + 1) + 2;
    localparam logic [PW-1:0] CntMax = {PW{1'b1}};

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [PW-1:0] cnt_q  [NREG];
    logic [PW-1:0] cnt_d  [NREG];
    logic          sb_err_q, sb_err_d;

    logic [XW-1:0]   rel_n    [NREG];
    logic [XW-1:0]   cnt_sum  [NREG];
    logic [XW-1:0]   busy_dif [NR];
    logic [NISS-1:0] iss_dup;

    assign sb_err = sb_err_q;

    // Releases are counted per port; write-port winner filtering does not apply.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            rel_n[r] = '0;
        end
        for (int w = 0; w < NW; w++) begin
            if (we[w] && wrel[w]) begin
                rel_n[waddr[w*AW +: AW]] = rel_n[waddr[w*AW +: AW]] + XW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rdata[i*DW +: DW] = regs_q[raddr[i*AW +: AW]];
            // Walk downwards so the lowest-index matching write port wins.
            for (int w = NW - 1; w >= 0; w--) begin
                if (we[w] && (waddr[w*AW +: AW] == raddr[i*AW +: AW])) begin
                    rdata[i*DW +: DW] = wdata[w*DW +: DW];
                end
            end
            if (!aresetn || (raddr[i*AW +: AW] == '0)) begin
                rdata[i*DW +: DW] = '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            busy_dif[i] = XW'(cnt_q[raddr[i*AW +: AW]]) - rel_n[raddr[i*AW +: AW]];
            rbusy[i] = aresetn && (raddr[i*AW +: AW] != '0) &&
                       !busy_dif[i][XW-1] && (busy_dif[i] != '0);
        end
    end

    always_comb begin
        iss_dup = '0;
        for (int j = 0; j < NISS; j++) begin
            for (int k = 0; k < j; k++) begin
                if (iss_valid[k] && (iss_addr[k*AW +: AW] == iss_addr[j*AW +: AW])) begin
                    iss_dup[j] = 1'b1;
                end
            end
        end
    end

    // Full check uses the pre-update counter; same-cycle releases do not free a slot.
    always_comb begin
        for (int j = 0; j < NISS; j++) begin
            iss_ready[j] = aresetn && !flush && iss_valid[j] &&
                           ((iss_addr[j*AW +: AW] == '0) ||
                            ((cnt_q[iss_addr[j*AW +: AW]] != CntMax) && !iss_dup[j]));
        end
    end

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_sum[r] = XW'(cnt_q[r]) - rel_n[r];
            for (int j = 0; j < NISS; j++) begin
                if (iss_ready[j] && (iss_addr[j*AW +: AW] == AW'(r))) begin
                    cnt_sum[r] = cnt_sum[r] + XW'(1);
                end
            end
            if ((r == 0) || flush) begin
                cnt_d[r] = '0;
            end else if (cnt_sum[r][XW-1]) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else if (cnt_sum[r][XW-2:PW] != '0) begin
                cnt_d[r] = CntMax;
            end else begin
                cnt_d[r] = cnt_sum[r][PW-1:0];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int w = NW - 1; w >= 0; w--) begin
            if (we[w] && (waddr[w*AW +: AW] != '0)) begin
                regs_d[waddr[w*AW +: AW]] = wdata[w*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: a driver computes expected outputs from a
// behavioural model and queues them; a monitor compares at the falling edge.
module tb_regfile_mp_sb;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int NR   = 4;
    localparam int NW   = 3;
    localparam int NISS = 2;
    localparam int PW   = 2;
    localparam int AW   = 5;
    localparam int CMAX = (1 << PW) - 1;

    logic              clk;
    logic              aresetn;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     wrel;
    logic [NISS-1:0]   iss_valid;
    logic [NISS*AW-1:0] iss_addr;
    logic [NISS-1:0]   iss_ready;
    logic              flush;
    logic              sb_err;

    regfile_mp_sb #(
        .NREG(NREG), .DW(DW), .NR(NR), .NW(NW), .NISS(NISS), .PW(PW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we(we), .waddr(waddr), .wdata(wdata), .wrel(wrel), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rbusy;
        logic [NISS-1:0]  rdy;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Stimulus fields
    logic [AW-1:0] ra [NR];
    logic          wen [NW];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic          wr [NW];
    logic          iv [NISS];
    logic [AW-1:0] ia [NISS];
    logic          fl;
    logic          rstn;

    // Reference model state
    logic [DW-1:0] mreg [NREG];
    int            mcnt [NREG];
    bit            merr;

    task automatic idle();
        for (int i = 0; i < NR; i++) ra[i] = '0;
        for (int w = 0; w < NW; w++) begin
            wen[w] = 1'b0; wa[w] = '0; wd[w] = '0; wr[w] = 1'b0;
        end
        for (int j = 0; j < NISS; j++) begin
            iv[j] = 1'b0; ia[j] = '0;
        end
        fl = 1'b0;
    endtask

    task automatic step();
        exp_t e;
        int rel [NREG];
        int acc [NREG];
        bit done [NREG];
        bit found, dup;
        int n;
        logic [DW-1:0] v;
        @(posedge clk);
        #1;
        aresetn = rstn;
        flush = fl;
        for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = ra[i];
        for (int w = 0; w < NW; w++) begin
            we[w] = wen[w]; waddr[w*AW +: AW] = wa[w]; wdata[w*DW +: DW] = wd[w];
            wrel[w] = wr[w];
        end
        for (int j = 0; j < NISS; j++) begin
            iss_valid[j] = iv[j]; iss_addr[j*AW +: AW] = ia[j];
        end
        for (int r = 0; r < NREG; r++) begin
            rel[r] = 0; acc[r] = 0; done[r] = 0;
        end
        e.rdata = '0; e.rbusy = '0; e.rdy = '0; e.err = merr;
        if (rstn) begin
            for (int w = 0; w < NW; w++) if (wen[w] && wr[w]) rel[wa[w]]++;
            for (int i = 0; i < NR; i++) begin
                if (ra[i] != 0) begin
                    v = mreg[ra[i]];
                    found = 0;
                    for (int w = 0; w < NW; w++) begin
                        if (!found && wen[w] && wa[w] == ra[i]) begin
                            v = wd[w]; found = 1;
                        end
                    end
                    e.rdata[i*DW +: DW] = v;
                    e.rbusy[i] = (mcnt[ra[i]] - rel[ra[i]]) > 0;
                end
            end
            for (int j = 0; j < NISS; j++) begin
                if (!fl && iv[j]) begin
                    dup = 0;
                    for (int k = 0; k < j; k++) if (iv[k] && ia[k] == ia[j]) dup = 1;
                    if (ia[j] == 0) e.rdy[j] = 1'b1;
                    else if (mcnt[ia[j]] < CMAX && !dup) begin
                        e.rdy[j] = 1'b1; acc[ia[j]]++;
                    end
                end
            end
        end
        exp_q.push_back(e);
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                mreg[r] = '0; mcnt[r] = 0;
            end
            merr = 0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wen[w] && wa[w] != 0 && !done[wa[w]]) begin
                    mreg[wa[w]] = wd[w]; done[wa[w]] = 1;
                end
            end
            for (int r = 1; r < NREG; r++) begin
                if (fl) mcnt[r] = 0;
                else begin
                    n = mcnt[r] + acc[r] - rel[r];
                    if (n < 0) begin
                        n = 0; merr = 1;
                    end
                    mcnt[r] = n;
                end
            end
        end
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                for (int i = 0; i < NR; i++) begin
                    checks++;
                    if (rdata[i*DW +: DW] !== e.rdata[i*DW +: DW]) begin
                        errors++;
                        $display("FAIL rdata[%0d] cyc=%0d got=%h exp=%h", i, cyc,
                                 rdata[i*DW +: DW], e.rdata[i*DW +: DW]);
                    end
                end
                checks++;
                if (rbusy !== e.rbusy) begin
                    errors++;
                    $display("FAIL rbusy cyc=%0d got=%b exp=%b", cyc, rbusy, e.rbusy);
                end
                checks++;
                if (iss_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL iss_ready cyc=%0d got=%b exp=%b", cyc, iss_ready, e.rdy);
                end
                checks++;
                if (sb_err !== e.err) begin
                    errors++;
                    $display("FAIL sb_err cyc=%0d got=%b exp=%b", cyc, sb_err, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rstn = 1'b0;
        aresetn = 1'b0; flush = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        wrel = '0; iss_valid = '0; iss_addr = '0;
        for (int r = 0; r < NREG; r++) begin
            mreg[r] = '0; mcnt[r] = 0;
        end
        merr = 0;
        repeat (2) @(posedge clk);
        step();
        // Reset read-out
        rstn = 1'b1;
        ra[0] = 5; ra[1] = 6; ra[2] = 7; ra[3] = 0;
        step();
        // Write with same-cycle bypass, then read from storage
        idle();
        wen[0] = 1; wa[0] = 3; wd[0] = 32'hDEADBEEF; ra[2] = 3;
        step();
        idle(); ra[2] = 3; step();
        // Three ports to r9, then a write to r0
        idle();
        for (int w = 0; w < NW; w++) begin
            wen[w] = 1; wa[w] = 9;
        end
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; ra[0] = 9;
        step();
        idle(); wen[0] = 1; wa[0] = 0; wd[0] = 32'hFF; ra[0] = 9; ra[1] = 0; step();
        idle(); ra[0] = 9; ra[1] = 0; step();
        // Fill r4's counter, then one more issue must be refused
        for (int k = 0; k < 4; k++) begin
            idle(); iv[0] = 1; ia[0] = 4; ra[0] = 4; step();
        end
        for (int k = 0; k < 3; k++) begin
            idle(); wen[1] = 1; wa[1] = 4; wd[1] = 32'h100 + k; wr[1] = 1; ra[0] = 4; step();
        end
        for (int k = 0; k < 2; k++) begin
            idle(); iv[1] = 1; ia[1] = 4; step();
        end
        idle(); iv[0] = 1; ia[0] = 4; wen[0] = 1; wa[0] = 4; wr[0] = 1; ra[3] = 4; step();
        idle(); ra[3] = 4; step();
        // Same-address issues, then flush with a concurrent issue
        idle(); iv[0] = 1; ia[0] = 8; iv[1] = 1; ia[1] = 8; ra[0] = 8; step();
        idle(); fl = 1; iv[0] = 1; ia[0] = 10; ra[0] = 8; ra[1] = 4; step();
        idle(); ra[0] = 8; ra[1] = 4; ra[2] = 10; step();
        // Underflow makes sb_err sticky; reset clears it and storage
        idle(); wen[2] = 1; wa[2] = 12; wd[2] = 32'h77; wr[2] = 1; ra[0] = 12; step();
        idle(); ra[0] = 12; step();
        idle(); ra[0] = 12; step();
        idle(); rstn = 0; wen[0] = 1; wa[0] = 12; wd[0] = 32'h5A; ra[0] = 12; step();
        rstn = 1; idle(); ra[0] = 12; ra[1] = 3; step();
        // Randomised traffic over a narrow address range to force collisions
        for (int c = 0; c < 3000; c++) begin
            idle();
            rstn = ($urandom_range(0, 299) != 0);
            fl = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NR; i++)
                ra[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            for (int w = 0; w < NW; w++) begin
                wen[w] = ($urandom_range(0, 2) == 0);
                wa[w] = AW'($urandom_range(0, 7));
                wd[w] = $urandom;
                wr[w] = ($urandom_range(0, 1) == 0);
            end
            for (int j = 0; j < NISS; j++) begin
                iv[j] = ($urandom_range(0, 1) == 0);
                ia[j] = AW'($urandom_range(0, 7));
            end
            step();
        end
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
